program_memory: RTL and testbench
=================================

Name: program_memory

Overview:
- Parametrised, loadable synchronous instruction memory for the MiniPC core.
- Replaces the hard-coded combinational instruction ROM.
- Programs are streamed in through a valid/ready loader port, e.g. from a UART boot block. After loading, the core fetches from it with one-cycle registered read latency.
- Out-of-range fetches and fetches during a load return a configurable default word.

Parameters:
- DATA_WIDTH, 28: instruction width in bits.
- ADDR_WIDTH, 16: width of the fetch address.
- DEPTH, 256: number of stored words; must be ≤ 2^ADDR_WIDTH.
- DEFAULT_WORD, 28'd0: word returned for out-of-range or blocked reads (the NOP encoding).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iAddress  in  ADDR_WIDTH  fetch address.
- iReadEnable  in  1  fetch request, sampled on rising edge.
- oInstruction  out  DATA_WIDTH  registered fetch data.
- oValid  out  1  oInstruction holds data for the request of the previous cycle.
- iLoadStart  in  1  one-cycle pulse; begins a program load at address 0.
- iLoadValid  in  1  iLoadData is valid.
- iLoadData  in  DATA_WIDTH  word to store.
- iLoadLast  in  1  qualifies the final word of a load.
- oLoadReady  out  1  memory accepts a load word this cycle.
- oLoaded  out  1  at least one complete load has finished since reset.
- oLoadCount  out  ADDR_WIDTH  number of words written by the last or current load.

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - outputs: oInstruction=DEFAULT_WORD, oValid=0, oLoadReady=0, oLoaded=0, oLoadCount=0;
  - internal: state=IDLE, write pointer=0.
  - Memory array contents are not cleared.
- State machine:
  - IDLE:
    - iLoadStart=1 → LOAD; pointer←0; oLoadCount←0.
  - LOAD:
    - oLoadReady=1.
    - A word is accepted when iLoadValid & oLoadReady: mem[ptr]←iLoadData, ptr←ptr+1, oLoadCount←ptr+1.
    - Accepted word with iLoadLast=1, or accepted word at ptr=DEPTH-1 → DONE.
    - iLoadStart in LOAD restarts the load: ptr←0, count←0, and no write that cycle.
  - DONE:
    - lasts one cycle; oLoadReady=0; oLoaded←1.
    - → IDLE.
- Fetch:
  - Fetch data is registered with 1-cycle latency.
  - A fetch is issued when iReadEnable=1 in IDLE or DONE. At the next edge: oValid←1; oInstruction←mem[iAddress] if iAddress<DEPTH, else DEFAULT_WORD.
  - iReadEnable=0 → next cycle oValid←0; oInstruction holds its previous value.
  - iReadEnable=1 in LOAD → next cycle oValid←0, oInstruction←DEFAULT_WORD. Fetches never see a partly loaded program.
- Read-during-write: not possible, because fetches are blocked in LOAD.
- Words beyond the last loaded address keep their old contents. After the first reset they are undefined. The core must not fetch them.
- iLoadValid outside LOAD is ignored.
- Reset asserted mid-load aborts the load. Already written words remain; oLoaded=0.
- Width rules: iAddress compared to DEPTH unsigned at full ADDR_WIDTH. Pointer is ADDR_WIDTH bits and never wraps, because the load terminates at DEPTH-1.

Optional Feature:
- Macro: PROGMEM_PARITY_EN.
- Defined:
  - Each word is stored with one extra even-parity bit computed from iLoadData at write time.
  - Each fetch recomputes parity. New output port oParityError (1 bit) is registered alongside oValid. It is 1 when the fetched in-range word's parity mismatches, else 0. Reset value 0.
  - Out-of-range and blocked fetches give oParityError=0.
  - Parity bit is checked even if the word was never loaded; undefined result is acceptable there.
- Not defined: no parity storage and no oParityError port. Behaviour is otherwise identical.

Test Plan:
- Reset, then fetch addr 0 with iReadEnable=1 → next cycle oValid=1. Before reset: oInstruction=DEFAULT_WORD, oValid=0, oLoadReady=0, oLoaded=0.
- Pulse iLoadStart; stream 0xA000001, 0xB000002, 0xC000003 with iLoadLast on the third → oLoadCount=3, one DONE cycle, oLoaded=1. Fetches of addrs 0,1,2 return those words one cycle after request.
- Fetch iAddress=300 (DEPTH=256) → oValid=1, oInstruction=DEFAULT_WORD.
- Set iReadEnable=1 during LOAD → oValid=0, oInstruction=DEFAULT_WORD. After return to IDLE, a fetch of addr 1 returns its new value.
- Load DEPTH=4 build with 6 words, no iLoadLast → only 4 accepted; oLoadReady drops after the 4th; oLoadCount=4. Assert Reset mid-way through a second load → outputs return to reset values immediately, asynchronously; oLoaded=0.
- PROGMEM_PARITY_EN: force-flip one stored bit of addr 2 via hierarchical reference; fetch addr 2 → oParityError=1 with oValid=1. Fetch addr 1 → oParityError=0.

Source files
------------

// File: rtl/program_memory.sv
// program_memory -- loadable synchronous instruction memory for the MiniPC core.
//
// Programs are streamed in over a valid/ready loader port. Once a load is
// done, the core fetches with one cycle of registered read latency. Fetches
// that are out of range, or that arrive while a load is running, return
// DEFAULT_WORD (the NOP encoding).
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-low reset
//   iAddress            fetch address (ADDR_WIDTH)
//   iReadEnable         fetch request
//   oInstruction        registered fetch data (DATA_WIDTH)
//   oValid              oInstruction answers the previous cycle's request
//   iLoadStart          pulse: (re)start a load at address 0
//   iLoadValid/Data/Last  load word stream; Last marks the final word
//   oLoadReady          a load word is accepted this cycle
//   oLoaded             a complete load has finished since reset
//   oLoadCount          words written by the last or current load
//   oParityError        (PROGMEM_PARITY_EN only) fetched word failed even parity
//
// Optional feature macro: PROGMEM_PARITY_EN. It stores one even-parity bit
// per word and checks that bit on each fetch.
module program_memory #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  input  logic                  iReadEnable,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oValid,
  input  logic                  iLoadStart,
  input  logic                  iLoadValid,
  input  logic [DATA_WIDTH-1:0] iLoadData,
  input  logic                  iLoadLast,
  output logic                  oLoadReady,
  output logic                  oLoaded,
`ifdef PROGMEM_PARITY_EN
  output logic                  oParityError,
`endif
  output logic [ADDR_WIDTH-1:0] oLoadCount
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROGMEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif
  // One extra bit so that DEPTH == 2^ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  logic [MEM_W-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  loaded_q, loaded_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;

  logic                  we;
  logic [MEM_W-1:0]      wr_data;
  logic [MEM_W-1:0]      rd_word;
  logic                  in_range;

`ifdef PROGMEM_PARITY_EN
  assign wr_data = {^iLoadData, iLoadData};
`else
  assign wr_data = iLoadData;
`endif

  // Index bits are only used when the full-width address check passes.
  assign in_range = ({1'b0, iAddress} < DEPTH_EXT);
  assign rd_word  = mem[iAddress[IDX_W-1:0]];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (iLoadStart) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (iLoadStart) begin
          // Restart wins over a same-cycle word: nothing is written.
          ptr_d   = '0;
          count_d = '0;
        end else if (iLoadValid) begin
          we      = 1'b1;
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
          count_d = ptr_q + ADDR_WIDTH'(1);
          // Stopping at the last slot keeps the pointer from ever wrapping.
          if (iLoadLast || ptr_q == LAST_PTR) state_d = DONE;
        end
      end
      DONE: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A partly loaded program is never visible to the core.
    if (iReadEnable) begin
      if (state_q == LOAD) begin
        instr_d = DEFAULT_WORD;
      end else begin
        valid_d = 1'b1;
        instr_d = in_range ? rd_word[DATA_WIDTH-1:0] : DEFAULT_WORD;
`ifdef PROGMEM_PARITY_EN
        perr_d  = in_range & (^rd_word);
`endif
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      loaded_q <= 1'b0;
      instr_q  <= DEFAULT_WORD;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
    end
  end

  // Storage is deliberately not reset; a reset mid-load leaves written words.
  always_ff @(posedge Clock) begin
    if (we) mem[ptr_q[IDX_W-1:0]] <= wr_data;
  end

  assign oInstruction = instr_q;
  assign oValid       = valid_q;
  assign oLoadReady   = (state_q == LOAD);
  assign oLoaded      = loaded_q;
  assign oLoadCount   = count_q;
`ifdef PROGMEM_PARITY_EN
  assign oParityError = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_program_memory.sv
// Testbench for program_memory: a DEPTH=256 instance driven through a fetch
// scoreboard, plus a DEPTH=4 instance for overflow and async-reset behaviour.
module tb_program_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 256 instance
  logic        rst_n, re, ls, lv, ll, valid, lr, loaded, perr;
  logic [15:0] addr, lcnt;
  logic [27:0] ld, instr;
  // DEPTH = 4 instance
  logic        b_rst_n, b_re, b_ls, b_lv, b_ll, b_valid, b_lr, b_loaded, b_perr;
  logic [15:0] b_addr, b_lcnt;
  logic [27:0] b_ld, b_instr;

  program_memory dut (
    .Clock(clk), .Reset(rst_n), .iAddress(addr), .iReadEnable(re),
    .oInstruction(instr), .oValid(valid), .iLoadStart(ls), .iLoadValid(lv),
    .iLoadData(ld), .iLoadLast(ll), .oLoadReady(lr), .oLoaded(loaded),
`ifdef PROGMEM_PARITY_EN
    .oParityError(perr),
`endif
    .oLoadCount(lcnt)
  );

  program_memory #(.DEPTH(4)) dut4 (
    .Clock(clk), .Reset(b_rst_n), .iAddress(b_addr), .iReadEnable(b_re),
    .oInstruction(b_instr), .oValid(b_valid), .iLoadStart(b_ls), .iLoadValid(b_lv),
    .iLoadData(b_ld), .iLoadLast(b_ll), .oLoadReady(b_lr), .oLoaded(b_loaded),
`ifdef PROGMEM_PARITY_EN
    .oParityError(b_perr),
`endif
    .oLoadCount(b_lcnt)
  );

`ifndef PROGMEM_PARITY_EN
  assign perr   = 1'b0;
  assign b_perr = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [27:0] w;
    logic        cw;  // compare the word (0 when it is undefined)
    logic        p;
  } exp_t;
  exp_t sb[$];

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Pop one expectation per clock edge while any are outstanding.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("fetch_valid", {31'd0, valid}, {31'd0, e.v});
      if (e.cw) chk("fetch_word", {4'd0, instr}, {4'd0, e.w});
`ifdef PROGMEM_PARITY_EN
      chk("fetch_parity", {31'd0, perr}, {31'd0, e.p});
`endif
    end
  end

  task automatic fetch(input logic [15:0] a, input logic ev, input logic [27:0] ew,
                       input logic cw, input logic ep);
    @(negedge clk);
    addr = a; re = 1'b1;
    sb.push_back('{ev, ew, cw, ep});
  endtask

  task automatic idle(input logic [27:0] hold, input logic cw);
    @(negedge clk);
    re = 1'b0;
    sb.push_back('{1'b0, hold, cw, 1'b0});
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; re = 0; ls = 0; lv = 0; ll = 0; addr = '0; ld = '0;
    b_rst_n = 1'b0; b_re = 0; b_ls = 0; b_lv = 0; b_ll = 0; b_addr = '0; b_ld = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", {4'd0, instr}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ready", {31'd0, lr}, 32'd0);
    chk("rst_loaded", {31'd0, loaded}, 32'd0);
    chk("rst_count", {16'd0, lcnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; b_rst_n = 1'b1;

    // Fetch before any load: valid goes high, data undefined.
    fetch(16'd0, 1'b1, 28'd0, 1'b0, 1'b0);
    idle(28'd0, 1'b0);
    drain();

    // Load three words, last flagged on the third.
    @(negedge clk); ls = 1'b1;
    @(negedge clk); ls = 1'b0;
    chk("load_ready", {31'd0, lr}, 32'd1);
    lv = 1'b1; ld = 28'hA000001;
    @(negedge clk); ld = 28'hB000002;
    @(negedge clk); ld = 28'hC000003; ll = 1'b1;
    @(negedge clk); lv = 1'b0; ll = 1'b0;
    chk("done_ready", {31'd0, lr}, 32'd0);
    chk("done_count", {16'd0, lcnt}, 32'd3);
    chk("done_loaded_pre", {31'd0, loaded}, 32'd0);
    @(negedge clk);
    chk("loaded", {31'd0, loaded}, 32'd1);
    chk("idle_ready", {31'd0, lr}, 32'd0);

    fetch(16'd0,   1'b1, 28'hA000001, 1'b1, 1'b0);
    fetch(16'd1,   1'b1, 28'hB000002, 1'b1, 1'b0);
    fetch(16'd2,   1'b1, 28'hC000003, 1'b1, 1'b0);
    idle(28'hC000003, 1'b1);
    fetch(16'd300, 1'b1, 28'd0, 1'b1, 1'b0);
    fetch(16'd256, 1'b1, 28'd0, 1'b1, 1'b0);
    fetch(16'd255, 1'b1, 28'd0, 1'b0, 1'b0);
    idle(28'd0, 1'b0);
    drain();

    // Reload two words while the core keeps fetching: fetches are blocked.
    @(negedge clk); ls = 1'b1; re = 1'b0;
    @(negedge clk); ls = 1'b0;
    re = 1'b1; addr = 16'd0; sb.push_back('{1'b0, 28'd0, 1'b1, 1'b0});
    lv = 1'b1; ld = 28'h1111111;
    @(negedge clk); ld = 28'h2222222; ll = 1'b1;
    sb.push_back('{1'b0, 28'd0, 1'b1, 1'b0});
    @(negedge clk); lv = 1'b0; ll = 1'b0; re = 1'b0;
    chk("reload_done_count", {16'd0, lcnt}, 32'd2);
    // Load words outside LOAD are dropped.
    @(negedge clk); lv = 1'b1; ld = 28'hFFFFFFF;
    @(negedge clk); lv = 1'b0;
    chk("ignored_count", {16'd0, lcnt}, 32'd2);
    fetch(16'd1, 1'b1, 28'h2222222, 1'b1, 1'b0);
    fetch(16'd0, 1'b1, 28'h1111111, 1'b1, 1'b0);
    fetch(16'd2, 1'b1, 28'hC000003, 1'b1, 1'b0);
    idle(28'hC000003, 1'b1);
    drain();

`ifdef PROGMEM_PARITY_EN
    dut.mem[2][0] = ~dut.mem[2][0];
    fetch(16'd2, 1'b1, 28'hC000002, 1'b1, 1'b1);
    fetch(16'd1, 1'b1, 28'h2222222, 1'b1, 1'b0);
    idle(28'h2222222, 1'b1);
    drain();
`endif

    // DEPTH=4: six words offered, no last flag; only four fit.
    @(negedge clk); b_ls = 1'b1;
    @(negedge clk); b_ls = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("d4_ready_%0d", i), {31'd0, b_lr}, (i < 4) ? 32'd1 : 32'd0);
      b_lv = 1'b1; b_ld = 28'h4000000 + 28'(i);
      @(negedge clk);
    end
    b_lv = 1'b0;
    chk("d4_count", {16'd0, b_lcnt}, 32'd4);
    chk("d4_loaded", {31'd0, b_loaded}, 32'd1);
    b_re = 1'b1; b_addr = 16'd3;
    @(posedge clk); #1;
    chk("d4_fetch3_v", {31'd0, b_valid}, 32'd1);
    chk("d4_fetch3_w", {4'd0, b_instr}, 32'h4000003);
    @(negedge clk); b_addr = 16'd4;
    @(posedge clk); #1;
    chk("d4_fetch4_v", {31'd0, b_valid}, 32'd1);
    chk("d4_fetch4_w", {4'd0, b_instr}, 32'd0);
    @(negedge clk); b_addr = 16'd0;
    @(posedge clk); #1;
    chk("d4_fetch0_w", {4'd0, b_instr}, 32'h4000000);

    // Second load, aborted by an asynchronous reset mid-cycle.
    @(negedge clk); b_re = 1'b0; b_ls = 1'b1;
    @(negedge clk); b_ls = 1'b0; b_lv = 1'b1; b_ld = 28'h5000000;
    @(negedge clk); b_ld = 28'h5000001;
    @(negedge clk); b_lv = 1'b0;
    chk("d4_mid_count", {16'd0, b_lcnt}, 32'd2);
    chk("d4_mid_ready", {31'd0, b_lr}, 32'd1);
    #2 b_rst_n = 1'b0;
    #1;
    chk("d4_arst_ready", {31'd0, b_lr}, 32'd0);
    chk("d4_arst_loaded", {31'd0, b_loaded}, 32'd0);
    chk("d4_arst_count", {16'd0, b_lcnt}, 32'd0);
    chk("d4_arst_valid", {31'd0, b_valid}, 32'd0);
    chk("d4_arst_instr", {4'd0, b_instr}, 32'd0);
    @(negedge clk); b_rst_n = 1'b1;
    // Words written before the abort survive.
    b_re = 1'b1; b_addr = 16'd1;
    @(posedge clk); #1;
    chk("d4_keep1_w", {4'd0, b_instr}, 32'h5000001);
    @(negedge clk); b_re = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
